// File: rtl/pipe_rate_change_ctrl_if.sv
// PIPE rate/width change interface: MAC request handshake, PIPE Rate/PCLKRate/
// width outputs, PCLK change handshake, per-lane PhyStatus and status flags.
// Handshake: a request is taken on a rising PCLK edge where rate_req_valid
// and rate_req_ready are both 1; rate_req_ready is 1 only while the
// controller is idle. A valid seen while not ready is dropped, not queued.
interface pipe_rate_change_ctrl_if #(
  parameter int LANESNUMBER = 16
);
  logic                   rate_req_valid;
  logic                   rate_req_ready;
  logic [3:0]             rate_req;
  logic [4:0]             pclkrate_req;
  logic [1:0]             width_req;
  logic [LANESNUMBER-1:0] lane_mask;
  logic [3:0]             Rate;
  logic [4:0]             PCLKRate;
  logic [1:0]             width;
  logic                   PclkChangeOk;
  logic                   PclkChangeAck;
  logic [LANESNUMBER-1:0] PhyStatus;
  logic                   busy;
  logic                   rate_done;
  logic                   rate_error;
  logic [1:0]             state_dbg;

  // Controller side.
  modport slave (
    input  rate_req_valid, rate_req, pclkrate_req, width_req, lane_mask,
    input  PclkChangeOk, PhyStatus,
    output rate_req_ready, Rate, PCLKRate, width, PclkChangeAck,
    output busy, rate_done, rate_error, state_dbg
  );

  // MAC/PHY side (driver of requests and PHY responses).
  modport master (
    output rate_req_valid, rate_req, pclkrate_req, width_req, lane_mask,
    output PclkChangeOk, PhyStatus,
    input  rate_req_ready, Rate, PCLKRate, width, PclkChangeAck,
    input  busy, rate_done, rate_error, state_dbg
  );
endinterface

// File: rtl/pipe_rate_change_ctrl.sv
// PIPE rate/width change controller. Accepts one change request at a time,
// drives Rate/PCLKRate/width, waits for PclkChangeOk, acknowledges, and
// collects PhyStatus from the masked lanes before pulsing rate_done.
// Optional macro PIPE_RATE_TIMEOUT_EN adds a handshake timeout that restores
// the previous settings and pulses rate_error.
module pipe_rate_change_ctrl #(
  parameter int LANESNUMBER    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    PCLK,
  input  logic                    phy_reset,
  pipe_rate_change_ctrl_if.slave  pipe
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_OK = 2'd1,
    ST_ACK     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // A timeout shorter than two cycles cannot cover even the best-case handshake.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t                 r_state;
  logic [3:0]             r_rate;
  logic [4:0]             r_pclkrate;
  logic [1:0]             r_width;
  logic                   r_ack;
  logic                   r_busy;
  logic                   r_done;
  logic [LANESNUMBER-1:0] r_mask;
  logic [LANESNUMBER-1:0] r_collect;

  logic [LANESNUMBER-1:0] w_hit;
  logic [LANESNUMBER-1:0] w_set;
  logic                   w_complete;
  logic                   w_same;

  // A PhyStatus pulse in the completing cycle counts toward the set.
  assign w_hit      = pipe.PhyStatus & r_mask;
  assign w_set      = r_collect | w_hit;
  assign w_complete = (w_set == r_mask);
  assign w_same     = (pipe.rate_req == r_rate) && (pipe.pclkrate_req == r_pclkrate) &&
                      (pipe.width_req == r_width);

`ifdef PIPE_RATE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_sv_rate;
  logic [4:0]       r_sv_pclkrate;
  logic [1:0]       r_sv_width;
  logic             r_error;
  logic             w_expired;

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Request acceptance, PCLK change handshake and PhyStatus collection.
  always_ff @(posedge PCLK) begin
    if (phy_reset) begin
      r_state    <= ST_IDLE;
      r_rate     <= '0;
      r_pclkrate <= '0;
      r_width    <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mask     <= '0;
      r_collect  <= '0;
`ifdef PIPE_RATE_TIMEOUT_EN
      r_cnt         <= '0;
      r_sv_rate     <= '0;
      r_sv_pclkrate <= '0;
      r_sv_width    <= '0;
      r_error       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef PIPE_RATE_TIMEOUT_EN
      r_error <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (pipe.rate_req_valid) begin
            r_mask <= pipe.lane_mask;
            r_busy <= 1'b1;
`ifdef PIPE_RATE_TIMEOUT_EN
            r_sv_rate     <= r_rate;
            r_sv_pclkrate <= r_pclkrate;
            r_sv_width    <= r_width;
            r_cnt         <= '0;
`endif
            if (w_same) begin
              // Nothing to change: report completion without a PHY handshake.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_rate     <= pipe.rate_req;
              r_pclkrate <= pipe.pclkrate_req;
              r_width    <= pipe.width_req;
              r_state    <= ST_WAIT_OK;
            end
          end
        end
        ST_WAIT_OK: begin
          if (pipe.PclkChangeOk) begin
            r_state   <= ST_ACK;
            r_ack     <= 1'b1;
            r_collect <= '0;
`ifdef PIPE_RATE_TIMEOUT_EN
            if (!w_expired) r_cnt <= r_cnt + 1'b1;
          end else if (w_expired) begin
            r_rate     <= r_sv_rate;
            r_pclkrate <= r_sv_pclkrate;
            r_width    <= r_sv_width;
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        ST_ACK: begin
          if (w_complete) begin
            r_state   <= ST_DONE;
            r_ack     <= 1'b0;
            r_done    <= 1'b1;
            r_collect <= w_set;
`ifdef PIPE_RATE_TIMEOUT_EN
          end else if (w_expired) begin
            r_rate     <= r_sv_rate;
            r_pclkrate <= r_sv_pclkrate;
            r_width    <= r_sv_width;
            r_ack      <= 1'b0;
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
`endif
          end else begin
            r_collect <= w_set;
`ifdef PIPE_RATE_TIMEOUT_EN
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign pipe.Rate           = r_rate;
  assign pipe.PCLKRate       = r_pclkrate;
  assign pipe.width          = r_width;
  assign pipe.PclkChangeAck  = r_ack;
  assign pipe.busy           = r_busy;
  assign pipe.rate_req_ready = ~r_busy;
  assign pipe.rate_done      = r_done;
  assign pipe.state_dbg      = r_state;
`ifdef PIPE_RATE_TIMEOUT_EN
  assign pipe.rate_error     = r_error;
`else
  assign pipe.rate_error     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// Directed bench for pipe_rate_change_ctrl: reset, full change, staggered
// PhyStatus, no-op request, zero mask, held valid, reset mid-handshake and
// the timeout / no-timeout behaviour selected by PIPE_RATE_TIMEOUT_EN.
module tb_pipe_rate_change_ctrl;
  localparam int LANES = 16;
  localparam int TMO   = 16;
  localparam int W     = 11;

  logic PCLK;
  logic phy_reset;
  int   n_vec;
  int   n_err;
  logic [W-1:0] exp_q[$];

  pipe_rate_change_ctrl_if #(.LANESNUMBER(LANES)) pif ();

  pipe_rate_change_ctrl #(
    .LANESNUMBER   (LANES),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK     (PCLK),
    .phy_reset(phy_reset),
    .pipe     (pif.slave)
  );

  // Clock and reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic req(input logic [3:0] r, input logic [4:0] p, input logic [1:0] w,
                     input logic [LANES-1:0] m);
    pif.rate_req_valid = 1'b1;
    pif.rate_req       = r;
    pif.pclkrate_req   = p;
    pif.width_req      = w;
    pif.lane_mask      = m;
  endtask

  task automatic exp_push(input logic [3:0] r, input logic [4:0] p, input logic [1:0] w);
    exp_q.push_back({r, p, w});
  endtask

  // Scoreboard: every rate_done pulse must match the next expected setting.
  always @(negedge PCLK) begin
    if (!phy_reset && pif.rate_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(pif.rate_done), 32'd0);
      end else begin
        chk("done_settings", 32'({pif.Rate, pif.PCLKRate, pif.width}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    phy_reset = 1'b1;
    pif.PclkChangeOk = 1'b0;
    pif.PhyStatus    = '0;
    // Request during reset must be dropped.
    req(4'd9, 5'd9, 2'd3, 16'hFFFF);
    step();
    step();
    phy_reset = 1'b0;
    pif.rate_req_valid = 1'b0;
    chk("rst_rate", 32'(pif.Rate), 32'd0);
    chk("rst_pclkrate", 32'(pif.PCLKRate), 32'd0);
    chk("rst_width", 32'(pif.width), 32'd0);
    chk("rst_ack", 32'(pif.PclkChangeAck), 32'd0);
    chk("rst_busy", 32'(pif.busy), 32'd0);
    chk("rst_done", 32'(pif.rate_done), 32'd0);
    chk("rst_error", 32'(pif.rate_error), 32'd0);
    chk("rst_ready", 32'(pif.rate_req_ready), 32'd1);
    chk("rst_state", 32'(pif.state_dbg), 32'd0);
    step();
    chk("rst_drop_busy", 32'(pif.busy), 32'd0);
    chk("rst_drop_rate", 32'(pif.Rate), 32'd0);

    // Full change 0 -> (2,2,1), Ok three cycles after acceptance.
    req(4'd2, 5'd2, 2'd1, 16'hFFFF);
    exp_push(4'd2, 5'd2, 2'd1);
    step();
    pif.rate_req_valid = 1'b0;
    chk("c1_rate", 32'(pif.Rate), 32'd2);
    chk("c1_pclkrate", 32'(pif.PCLKRate), 32'd2);
    chk("c1_width", 32'(pif.width), 32'd1);
    chk("c1_busy", 32'(pif.busy), 32'd1);
    chk("c1_ready", 32'(pif.rate_req_ready), 32'd0);
    chk("c1_state_wait", 32'(pif.state_dbg), 32'd1);
    step();
    chk("c1_noack_a", 32'(pif.PclkChangeAck), 32'd0);
    step();
    chk("c1_noack_b", 32'(pif.PclkChangeAck), 32'd0);
    pif.PclkChangeOk = 1'b1;
    step();
    pif.PclkChangeOk = 1'b0;
    chk("c1_ack", 32'(pif.PclkChangeAck), 32'd1);
    chk("c1_state_ack", 32'(pif.state_dbg), 32'd2);
    step();
    chk("c1_ack_hold", 32'(pif.PclkChangeAck), 32'd1);
    chk("c1_nodone", 32'(pif.rate_done), 32'd0);
    pif.PhyStatus = 16'hFFFF;
    step();
    pif.PhyStatus = '0;
    chk("c1_done", 32'(pif.rate_done), 32'd1);
    chk("c1_ack_drop", 32'(pif.PclkChangeAck), 32'd0);
    chk("c1_done_busy", 32'(pif.busy), 32'd1);
    step();
    chk("c1_done_once", 32'(pif.rate_done), 32'd0);
    chk("c1_idle_busy", 32'(pif.busy), 32'd0);
    chk("c1_final_rate", 32'(pif.Rate), 32'd2);

    // Staggered PhyStatus on mask 000F; PhyStatus in WAIT_OK is ignored and
    // dropping Ok during ACK does not matter.
    req(4'd3, 5'd4, 2'd2, 16'h000F);
    exp_push(4'd3, 5'd4, 2'd2);
    step();
    pif.rate_req_valid = 1'b0;
    pif.PhyStatus = 16'h000F;
    pif.PclkChangeOk = 1'b1;
    step();
    pif.PhyStatus = '0;
    pif.PclkChangeOk = 1'b0;
    chk("c2_ack", 32'(pif.PclkChangeAck), 32'd1);
    step();
    chk("c2_wait_ignored", 32'(pif.rate_done), 32'd0);
    pif.PhyStatus = 16'h0003;
    step();
    pif.PhyStatus = '0;
    chk("c2_t0_nodone", 32'(pif.rate_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c2_hold_ack", 32'(pif.PclkChangeAck), 32'd1);
    end
    pif.PhyStatus = 16'hFF0C;
    step();
    pif.PhyStatus = '0;
    chk("c2_done", 32'(pif.rate_done), 32'd1);
    chk("c2_error", 32'(pif.rate_error), 32'd0);
    step();
    chk("c2_rate", 32'(pif.Rate), 32'd3);
    chk("c2_pclkrate", 32'(pif.PCLKRate), 32'd4);
    chk("c2_width", 32'(pif.width), 32'd2);
    chk("c2_idle", 32'(pif.busy), 32'd0);

    // No-op request equal to current settings.
    req(4'd3, 5'd4, 2'd2, 16'hFFFF);
    exp_push(4'd3, 5'd4, 2'd2);
    step();
    pif.rate_req_valid = 1'b0;
    chk("noop_done", 32'(pif.rate_done), 32'd1);
    chk("noop_ack", 32'(pif.PclkChangeAck), 32'd0);
    chk("noop_rate", 32'(pif.Rate), 32'd3);
    step();
    chk("noop_idle", 32'(pif.busy), 32'd0);
    chk("noop_done_off", 32'(pif.rate_done), 32'd0);

    // All-zero mask completes after one ACK cycle.
    req(4'd1, 5'd1, 2'd0, 16'h0000);
    exp_push(4'd1, 5'd1, 2'd0);
    step();
    pif.rate_req_valid = 1'b0;
    pif.PclkChangeOk = 1'b1;
    step();
    pif.PclkChangeOk = 1'b0;
    chk("zm_ack", 32'(pif.PclkChangeAck), 32'd1);
    step();
    chk("zm_done", 32'(pif.rate_done), 32'd1);
    chk("zm_ack_off", 32'(pif.PclkChangeAck), 32'd0);
    step();

    // Valid held high across a whole change: one change, then next after DONE.
    req(4'd5, 5'd6, 2'd3, 16'h0001);
    exp_push(4'd5, 5'd6, 2'd3);
    step();
    chk("hv_rate", 32'(pif.Rate), 32'd5);
    req(4'd7, 5'd7, 2'd3, 16'h0001);
    pif.PclkChangeOk = 1'b1;
    step();
    pif.PclkChangeOk = 1'b0;
    pif.PhyStatus = 16'h0001;
    chk("hv_ack", 32'(pif.PclkChangeAck), 32'd1);
    chk("hv_not_queued", 32'(pif.Rate), 32'd5);
    step();
    pif.PhyStatus = '0;
    chk("hv_done", 32'(pif.rate_done), 32'd1);
    chk("hv_done_rate", 32'(pif.Rate), 32'd5);
    step();
    chk("hv_idle_ready", 32'(pif.rate_req_ready), 32'd1);
    chk("hv_idle_rate", 32'(pif.Rate), 32'd5);
    exp_push(4'd7, 5'd7, 2'd3);
    step();
    pif.rate_req_valid = 1'b0;
    chk("hv_second_rate", 32'(pif.Rate), 32'd7);
    chk("hv_second_busy", 32'(pif.busy), 32'd1);
    pif.PclkChangeOk = 1'b1;
    step();
    pif.PclkChangeOk = 1'b0;
    pif.PhyStatus = 16'h0001;
    step();
    pif.PhyStatus = '0;
    chk("hv_second_done", 32'(pif.rate_done), 32'd1);
    step();

    // Reset while in ACK, then a new request right away.
    req(4'd2, 5'd2, 2'd1, 16'hFFFF);
    step();
    pif.rate_req_valid = 1'b0;
    pif.PclkChangeOk = 1'b1;
    step();
    pif.PclkChangeOk = 1'b0;
    chk("ra_ack", 32'(pif.PclkChangeAck), 32'd1);
    phy_reset = 1'b1;
    step();
    phy_reset = 1'b0;
    chk("ra_rate", 32'(pif.Rate), 32'd0);
    chk("ra_pclkrate", 32'(pif.PCLKRate), 32'd0);
    chk("ra_width", 32'(pif.width), 32'd0);
    chk("ra_ack_off", 32'(pif.PclkChangeAck), 32'd0);
    chk("ra_busy", 32'(pif.busy), 32'd0);
    chk("ra_done", 32'(pif.rate_done), 32'd0);
    req(4'd4, 5'd3, 2'd1, 16'h0002);
    exp_push(4'd4, 5'd3, 2'd1);
    step();
    pif.rate_req_valid = 1'b0;
    chk("ra_new_busy", 32'(pif.busy), 32'd1);
    chk("ra_new_rate", 32'(pif.Rate), 32'd4);
    pif.PclkChangeOk = 1'b1;
    step();
    pif.PclkChangeOk = 1'b0;
    pif.PhyStatus = 16'h0002;
    step();
    pif.PhyStatus = '0;
    chk("ra_new_done", 32'(pif.rate_done), 32'd1);
    step();

    // Ok never arrives.
    req(4'd1, 5'd2, 2'd3, 16'h0000);
    step();
    pif.rate_req_valid = 1'b0;
    chk("to_rate_loaded", 32'(pif.Rate), 32'd1);
`ifdef PIPE_RATE_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("to_no_error_yet", 32'(pif.rate_error), 32'd0);
    end
    step();
    chk("to_error", 32'(pif.rate_error), 32'd1);
    chk("to_rate_restored", 32'(pif.Rate), 32'd4);
    chk("to_pclkrate_restored", 32'(pif.PCLKRate), 32'd3);
    chk("to_width_restored", 32'(pif.width), 32'd1);
    chk("to_idle", 32'(pif.busy), 32'd0);
    chk("to_ack", 32'(pif.PclkChangeAck), 32'd0);
    step();
    chk("to_error_once", 32'(pif.rate_error), 32'd0);
`else
    for (int i = 0; i < 40; i++) step();
    chk("nto_still_busy", 32'(pif.busy), 32'd1);
    chk("nto_no_error", 32'(pif.rate_error), 32'd0);
    chk("nto_rate_kept", 32'(pif.Rate), 32'd1);
    phy_reset = 1'b1;
    step();
    phy_reset = 1'b0;
    chk("nto_reset_idle", 32'(pif.busy), 32'd0);
`endif

    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_rate_change_ctrl.md
PIPE_RATE_CHANGE_CTRL -- requirements
Module: pipe_rate_change_ctrl

Interface
REQ-001 SHALL have parameter LANESNUMBER, default 16, number of PIPE lanes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, handshake timeout in PCLK cycles, minimum 2.
REQ-003 SHALL have port PCLK  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port phy_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rate_req_valid  input  1  MAC requests a rate/width change.
REQ-006 SHALL have port rate_req_ready  output  1  block can accept a request.
REQ-007 SHALL have port rate_req  input  4  target Rate.
REQ-008 SHALL have port pclkrate_req  input  5  target PCLKRate.
REQ-009 SHALL have port width_req  input  2  target width.
REQ-010 SHALL have port lane_mask  input  LANESNUMBER  lanes whose PhyStatus must be collected.
REQ-011 SHALL have port Rate  output  4  registered PIPE Rate.
REQ-012 SHALL have port PCLKRate  output  5  registered PIPE PCLKRate.
REQ-013 SHALL have port width  output  2  registered PIPE width.
REQ-014 SHALL have port PclkChangeOk  input  1  PHY ready for the PCLK change.
REQ-015 SHALL have port PclkChangeAck  output  1  MAC acknowledges the PCLK change.
REQ-016 SHALL have port PhyStatus  input  LANESNUMBER  per-lane completion pulses.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port rate_done  output  1  one-cycle pulse on successful completion.
REQ-019 SHALL have port rate_error  output  1  one-cycle pulse on timeout.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_OK, ACK, DONE; rate_req_ready=1 only in IDLE.
REQ-021 In IDLE, on rate_req_valid=1, SHALL accept the request, latch lane_mask, and save current Rate/PCLKRate/width as a restore copy.
REQ-022 If the accepted triple equals current Rate/PCLKRate/width, SHALL go to DONE with outputs unchanged (no-op).
REQ-023 Otherwise SHALL load Rate/PCLKRate/width from the request on the accepting edge (visible next cycle) and go to WAIT_OK.
REQ-024 In WAIT_OK, SHALL ignore PhyStatus and go to ACK on the first cycle PclkChangeOk=1.
REQ-025 In ACK, SHALL drive PclkChangeAck=1 and OR (PhyStatus AND latched mask) into a sticky collect register cleared on ACK entry.
REQ-026 SHALL go to DONE when (collect OR (PhyStatus AND mask)) equals the mask, so a pulse in the cycle the set completes counts; PclkChangeAck is 0 from DONE onward.
REQ-027 A latched all-zero mask SHALL complete after exactly one ACK cycle.
REQ-028 DONE SHALL last one cycle with rate_done=1, then return to IDLE; no request is accepted in DONE.
REQ-029 rate_req_valid while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 PclkChangeOk deasserting during ACK SHALL NOT affect progress.
REQ-031 Best-case change latency: accept edge N, Ok sampled N+1, ACK N+2, done pulse N+3 with same-cycle PhyStatus.

Reset
REQ-032 phy_reset=1 SHALL force IDLE on the next edge from any state, including mid-handshake.
REQ-033 Reset values SHALL be: Rate=0, PCLKRate=0, width=0, PclkChangeAck=0, busy=0, rate_done=0, rate_error=0, collect=0, timeout counter=0.
REQ-034 A request presented in the reset cycle SHALL be dropped.

Configuration
REQ-035 Macro PIPE_RATE_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT_OK and count in WAIT_OK and ACK.
REQ-036 On count TIMEOUT_CYCLES-1 without progress: restore the saved Rate/PCLKRate/width, drive PclkChangeAck=0, pulse rate_error for one cycle, and return to IDLE.
REQ-037 Macro PIPE_RATE_TIMEOUT_EN undefined: SHALL have no counter, hold rate_error=0, and wait indefinitely in WAIT_OK and ACK.

Verification
REQ-038 Change from Rate 0 to rate_req=2, pclkrate_req=2, width_req=1, mask=16'hFFFF; Ok 3 cycles later; PhyStatus all lanes one cycle -> Rate=2, Ack high until that cycle, single rate_done.
REQ-039 mask=16'h000F; PhyStatus lanes 0,1 at cycle t, lanes 2,3 at t+4, others never -> DONE at t+5, no timeout.
REQ-040 Request equal to current settings -> rate_done one cycle later, Ack never asserted, outputs unchanged.
REQ-041 With PIPE_RATE_TIMEOUT_EN and TIMEOUT_CYCLES=16, Ok never asserted -> rate_error after 16 cycles, Rate restored to 0, back to IDLE.
REQ-042 phy_reset asserted in ACK -> next cycle all outputs at reset values; a new request next cycle is accepted.
REQ-043 rate_req_valid held high across a whole change -> exactly one change performed, next acceptance only after DONE.
